// File: rtl/key_debouncer_if.sv
// Button-side bundle for key_debouncer: raw pin in, debounced level and event strobes out.
// master is the debouncer side, slave is the consumer that drives the pin and uses the strobes.
interface key_debouncer_if;
  logic sw_i;
  logic sw_state_o;
  logic sw_down_o;
  logic sw_up_o;
  logic sw_rpt_o;
  logic sw_press_o;

  modport master (
    input  sw_i,
    output sw_state_o,
    output sw_down_o,
    output sw_up_o,
    output sw_rpt_o,
    output sw_press_o
  );

  modport slave (
    output sw_i,
    input  sw_state_o,
    input  sw_down_o,
    input  sw_up_o,
    input  sw_rpt_o,
    input  sw_press_o
  );
endinterface

// File: rtl/key_debouncer.sv
// Push-button debouncer: two-flop synchronizer, consecutive-sample stability counter,
// press/release strobes and an optional hold-to-repeat FSM. All outputs come from flops.
module key_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  key_debouncer_if.master key_if
);

  localparam int unsigned CntW   = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TimMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TimW   = $clog2(TimMax + 1);

  localparam logic [CntW-1:0] CntLast    = CntW'(STABLE_CYCLES - 1);
  localparam logic [TimW-1:0] DelayLast  = TimW'(REPEAT_DELAY - 1);
  localparam logic [TimW-1:0] PeriodLast = TimW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StReleased, StHoldWait, StRepeating} rpt_st_e;

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TimW-1:0] tim_q, tim_d;
  rpt_st_e         fsm_q, fsm_d;
  logic            state_q, state_d;
  logic            down_q, down_d;
  logic            up_q, up_d;
  logic            rpt_q, rpt_d;
  logic            press_q, press_d;
  logic            pressed;
  logic            toggle;

  // Pressed sample is 1 when the button is held, whatever the pin polarity.
  assign pressed = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    sync1_d = key_if.sw_i;
    sync2_d = sync1_q;

    toggle = 1'b0;
    cnt_d  = '0;
    if (pressed != state_q) begin
      if (cnt_q == CntLast) begin
        toggle = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    state_d = state_q ^ toggle;
    down_d  = toggle & ~state_q;
    up_d    = toggle & state_q;

    fsm_d = fsm_q;
    tim_d = tim_q;
    rpt_d = 1'b0;
    if (REPEAT_EN) begin
      case (fsm_q)
        StReleased: begin
          tim_d = '0;
          if (down_d) fsm_d = StHoldWait;
        end
        StHoldWait: begin
          if (tim_q == DelayLast) begin
            fsm_d = StRepeating;
            tim_d = '0;
            rpt_d = 1'b1;
          end else begin
            tim_d = tim_q + 1'b1;
          end
        end
        StRepeating: begin
          if (tim_q == PeriodLast) begin
            tim_d = '0;
            rpt_d = 1'b1;
          end else begin
            tim_d = tim_q + 1'b1;
          end
        end
        default: begin
          fsm_d = StReleased;
          tim_d = '0;
        end
      endcase
      // A release wins over a coincident repeat expiry.
      if (up_d) begin
        fsm_d = StReleased;
        tim_d = '0;
        rpt_d = 1'b0;
      end
    end

    press_d = down_d | rpt_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
      cnt_q   <= '0;
      tim_q   <= '0;
      fsm_q   <= StReleased;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      rpt_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      tim_q   <= tim_d;
      fsm_q   <= fsm_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
      rpt_q   <= rpt_d;
      press_q <= press_d;
    end
  end

  assign key_if.sw_state_o = state_q;
  assign key_if.sw_down_o  = down_q;
  assign key_if.sw_up_o    = up_q;
  assign key_if.sw_rpt_o   = rpt_q;
  assign key_if.sw_press_o = press_q;

endmodule
